// File: rtl/fetch_unit_pkg.sv
// Shared CPU definitions for the fetch stage: opcode constants, instruction
// field positions and the fetch FSM encoding.
package fetch_unit_pkg;
  localparam logic [3:0] OP_NOOP = 4'd0;
  localparam logic [3:0] OP_HLT  = 4'd15;

  localparam int OPC_LSB = 28;
  localparam int MM_LSB  = 24;
  localparam int IMM_W   = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HALT = 2'd3
  } fsm_e;

  function automatic logic [3:0] opc_of(input logic [31:0] w);
    return w[OPC_LSB +: 4];
  endfunction

  function automatic logic [3:0] mm_of(input logic [31:0] w);
    return w[MM_LSB +: 4];
  endfunction
endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read bus between the fetch unit (master) and memory (slave).
interface fetch_unit_if #(parameter int ADDR_W = 16);
  logic              im_req;
  logic [ADDR_W-1:0] im_addr;
  logic              im_rdy;
  logic [31:0]       im_data;

  modport master (output im_req, im_addr, input  im_rdy, im_data);
  modport slave  (input  im_req, im_addr, output im_rdy, im_data);
endinterface

// File: rtl/fetch_unit_pc_next.sv
// Combinational next-PC selection: clear, increment, absolute or relative branch.
module pc_next #(
  parameter int ADDR_W = 16
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] abs_tgt,
  input  logic [15:0]       rel_off,
  input  logic              pc_rst,
  input  logic              pc_write,
  input  logic              pc_sel,
  input  logic              br_sel,
  output logic              pc_en,
  output logic [ADDR_W-1:0] pc_nxt
);
  logic [ADDR_W-1:0] rel_ext;

  // signed size cast sign-extends the 16-bit offset to the PC width
  assign rel_ext = ADDR_W'($signed(rel_off));

  always_comb begin
    pc_en  = pc_rst | pc_write;
    pc_nxt = pc;
    if (pc_rst)           pc_nxt = '0;
    else if (pc_write) begin
      if (!pc_sel)        pc_nxt = pc + ADDR_W'(1);
      else if (br_sel)    pc_nxt = abs_tgt;
      else                pc_nxt = pc + rel_ext;
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues one memory read per FETCH pulse, loads the IR,
// handles memory timeouts and parks in HALT on a HLT opcode.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_f,
  input  logic              fetch,
  input  logic              pc_write,
  input  logic              pc_sel,
  input  logic              br_sel,
  input  logic              pc_rst,
  fetch_unit_if.master      im,
  output logic [31:0]       instr,
  output logic [3:0]        opcode,
  output logic [3:0]        mm,
  output logic [ADDR_W-1:0] pc,
  output logic              ir_valid,
  output logic              busy,
  output logic              fetch_err,
  output logic              halted
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  fsm_e              state, state_nxt;
  logic              accept, capture, expire, load, is_hlt;
  logic [CNT_W-1:0]  wait_cnt;
  logic              im_req_q;
  logic [ADDR_W-1:0] im_addr_q;
  logic              pc_en;
  logic [ADDR_W-1:0] pc_nxt;

  assign is_hlt = (opc_of(im.im_data) == OP_HLT);

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    expire    = 1'b0;
    case (state)
      ST_IDLE: if (fetch) begin
        accept    = 1'b1;
        state_nxt = ST_REQ;
      end
      ST_REQ:  state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (im.im_rdy) begin
          capture   = 1'b1;
          state_nxt = is_hlt ? ST_HALT : ST_IDLE;
        end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
          expire    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign load = capture | expire;

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      im_req_q  <= 1'b0;
      im_addr_q <= '0;
      instr     <= '0;
      wait_cnt  <= '0;
      ir_valid  <= 1'b0;
      fetch_err <= 1'b0;
      halted    <= 1'b0;
      pc        <= '0;
    end else begin
      ir_valid <= load;
      wait_cnt <= (state == ST_WAIT && !load) ? wait_cnt + CNT_W'(1) : '0;
      // address is frozen at accept; PC may move freely while the read is in flight
      if (accept) begin
        im_req_q  <= 1'b1;
        im_addr_q <= pc;
        fetch_err <= 1'b0;
      end else if (load) begin
        im_req_q  <= 1'b0;
      end
      if (capture)     instr <= im.im_data;
      else if (expire) instr <= {OP_NOOP, 28'd0};
      if (expire)             fetch_err <= 1'b1;
      if (capture && is_hlt)  halted    <= 1'b1;
      if (pc_en)              pc        <= pc_nxt;
    end
  end

  pc_next #(.ADDR_W(ADDR_W)) u_pc_next (
    .pc       (pc),
    .abs_tgt  (instr[ADDR_W-1:0]),
    .rel_off  (instr[15:0]),
    .pc_rst   (pc_rst),
    .pc_write (pc_write),
    .pc_sel   (pc_sel),
    .br_sel   (br_sel),
    .pc_en    (pc_en),
    .pc_nxt   (pc_nxt)
  );

  assign im.im_req  = im_req_q;
  assign im.im_addr = im_addr_q;
  assign busy       = (state == ST_REQ) || (state == ST_WAIT);
  assign opcode     = opc_of(instr);
  assign mm         = mm_of(instr);
endmodule

// File: tb/tb_fetch_unit.sv
// Scenario bench for fetch_unit: expected IR words are queued when memory
// answers and checked when IR_VALID pulses.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_f = 1'b1;
  logic        fetch = 1'b0, pc_write = 1'b0, pc_sel = 1'b0, br_sel = 1'b0, pc_rst = 1'b0;
  logic [31:0] instr;
  logic [3:0]  opcode, mm;
  logic [15:0] pc;
  logic        ir_valid, busy, fetch_err, halted;

  int errors = 0, checks = 0, ir_count = 0;
  logic [31:0] exp_q[$];

  fetch_unit_if #(.ADDR_W(16)) im ();

  fetch_unit #(.ADDR_W(16), .TIMEOUT(16)) dut (
    .clk       (clk),
    .rst_f     (rst_f),
    .fetch     (fetch),
    .pc_write  (pc_write),
    .pc_sel    (pc_sel),
    .br_sel    (br_sel),
    .pc_rst    (pc_rst),
    .im        (im),
    .instr     (instr),
    .opcode    (opcode),
    .mm        (mm),
    .pc        (pc),
    .ir_valid  (ir_valid),
    .busy      (busy),
    .fetch_err (fetch_err),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin : scoreboard
    logic [31:0] e;
    if (ir_valid === 1'b1) begin
      ir_count++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: IR_VALID with instr=%h, nothing expected", instr);
      end else begin
        e = exp_q.pop_front();
        if (instr !== e) begin
          errors++;
          $display("FAIL sb_instr: instr=%h want %h", instr, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_fetch(input logic [31:0] data, input logic [15:0] exp_addr,
                           input int gap, input string tag);
    fetch = 1'b1;
    tick();
    fetch = 1'b0;
    checks++;
    if (im.im_req !== 1'b1 || im.im_addr !== exp_addr || busy !== 1'b1 || fetch_err !== 1'b0) begin
      errors++;
      $display("FAIL %s_req: req=%b addr=%h busy=%b err=%b want 1 %h 1 0",
               tag, im.im_req, im.im_addr, busy, fetch_err, exp_addr);
    end
    tick();
    repeat (gap) tick();
    im.im_rdy = 1'b1;
    im.im_data = data;
    exp_q.push_back(data);
    tick();
    im.im_rdy = 1'b0;
    checks++;
    if (instr !== data || im.im_req !== 1'b0) begin
      errors++;
      $display("FAIL %s_cap: instr=%h req=%b want %h 0", tag, instr, im.im_req, data);
    end
    tick();
  endtask

  task automatic pc_op(input logic r, input logic w, input logic s, input logic b,
                       input logic [15:0] exp, input string tag);
    pc_rst = r; pc_write = w; pc_sel = s; br_sel = b;
    tick();
    pc_rst = 1'b0; pc_write = 1'b0; pc_sel = 1'b0; br_sel = 1'b0;
    checks++;
    if (pc !== exp) begin
      errors++;
      $display("FAIL %s: pc=%h want %h", tag, pc, exp);
    end
  endtask

  task automatic test_reset();
    im.im_rdy = 1'b0;
    im.im_data = '0;
    #2 rst_f = 1'b0;
    #1;
    checks++;
    if ({im.im_req, busy, ir_valid, fetch_err, halted} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: req,busy,irv,err,halt=%b want 00000",
               {im.im_req, busy, ir_valid, fetch_err, halted});
    end
    checks++;
    if (pc !== 16'h0 || instr !== 32'h0 || im.im_addr !== 16'h0) begin
      errors++;
      $display("FAIL reset_regs: pc=%h instr=%h addr=%h want 0", pc, instr, im.im_addr);
    end
    tick();
    rst_f = 1'b1;
    tick();
  endtask

  task automatic test_basic_fetch();
    int n0;
    n0 = ir_count;
    run_fetch(32'h8123_0004, 16'h0000, 1, "basic");
    checks++;
    if (opcode !== 4'd8 || mm !== 4'd1) begin
      errors++;
      $display("FAIL basic_fields: opcode=%0d mm=%0d want 8 1", opcode, mm);
    end
    checks++;
    if (ir_count !== n0 + 1) begin
      errors++;
      $display("FAIL basic_irv_count: pulses=%0d want 1", ir_count - n0);
    end
    run_fetch(32'h0000_1234, 16'h0000, 0, "min_latency");
  endtask

  task automatic test_branch();
    run_fetch(32'h0000_0010, 16'h0000, 0, "br_setup");
    pc_op(0, 1, 1, 1, 16'h0010, "abs_setup");
    run_fetch(32'h0000_FFFC, 16'h0010, 2, "br_neg");
    pc_op(0, 1, 1, 0, 16'h000C, "rel_neg");
    for (int i = 1; i <= 4; i++) pc_op(0, 1, 0, 0, 16'(16'h000C + i), "seq_inc");
    run_fetch(32'h0000_0040, 16'h0010, 1, "br_abs");
    pc_op(0, 1, 1, 1, 16'h0040, "abs_0040");
    run_fetch(32'h0000_0008, 16'h0040, 0, "br_pos");
    pc_op(0, 1, 1, 0, 16'h0048, "rel_pos");
    pc_op(0, 0, 1, 1, 16'h0048, "no_write_hold");
  endtask

  task automatic test_wrap();
    run_fetch(32'h0000_FFFF, 16'h0048, 0, "wrap_setup");
    pc_op(0, 1, 1, 1, 16'hFFFF, "abs_ffff");
    pc_op(0, 1, 0, 0, 16'h0000, "seq_wrap");
    pc_op(0, 1, 0, 0, 16'h0001, "seq_one");
    pc_op(1, 1, 0, 0, 16'h0000, "rst_over_write");
    pc_op(0, 1, 1, 0, 16'hFFFF, "rel_wrap");
    pc_op(1, 0, 0, 0, 16'h0000, "rst_only");
  endtask

  task automatic test_timeout();
    fetch = 1'b1;
    tick();
    fetch = 1'b0;
    tick();
    exp_q.push_back(32'h0);
    repeat (15) tick();
    checks++;
    if (busy !== 1'b1 || fetch_err !== 1'b0 || im.im_req !== 1'b1) begin
      errors++;
      $display("FAIL to_early: busy=%b err=%b req=%b want 1 0 1", busy, fetch_err, im.im_req);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || instr !== 32'h0 || fetch_err !== 1'b1 || im.im_req !== 1'b0) begin
      errors++;
      $display("FAIL to_expire: busy=%b instr=%h err=%b req=%b want 0 0 1 0",
               busy, instr, fetch_err, im.im_req);
    end
    tick();
    run_fetch(32'h2000_0005, 16'h0000, 3, "to_recover");
  endtask

  task automatic test_back_to_back_halt();
    int n0;
    fetch = 1'b1;
    tick();
    fetch = 1'b0;
    tick();
    fetch = 1'b1; pc_write = 1'b1; pc_sel = 1'b0;
    tick();
    fetch = 1'b0; pc_write = 1'b0;
    checks++;
    if (im.im_addr !== 16'h0000 || busy !== 1'b1 || im.im_req !== 1'b1 || pc !== 16'h0001) begin
      errors++;
      $display("FAIL b2b_ignored: addr=%h busy=%b req=%b pc=%h want 0000 1 1 0001",
               im.im_addr, busy, im.im_req, pc);
    end
    im.im_rdy = 1'b1;
    im.im_data = 32'hF000_0000;
    exp_q.push_back(32'hF000_0000);
    tick();
    im.im_rdy = 1'b0;
    checks++;
    if (halted !== 1'b1 || busy !== 1'b0 || opcode !== 4'd15) begin
      errors++;
      $display("FAIL halt_enter: halted=%b busy=%b opcode=%0d want 1 0 15", halted, busy, opcode);
    end
    tick();
    n0 = ir_count;
    fetch = 1'b1;
    tick();
    fetch = 1'b0;
    repeat (3) tick();
    checks++;
    if (im.im_req !== 1'b0 || busy !== 1'b0 || halted !== 1'b1 || ir_count !== n0) begin
      errors++;
      $display("FAIL halt_ignore: req=%b busy=%b halted=%b pulses=%0d want 0 0 1 0",
               im.im_req, busy, halted, ir_count - n0);
    end
  endtask

  task automatic test_reset_abort();
    int n0;
    rst_f = 1'b0;
    tick();
    rst_f = 1'b1;
    tick();
    checks++;
    if (halted !== 1'b0 || instr !== 32'h0) begin
      errors++;
      $display("FAIL halt_cleared: halted=%b instr=%h want 0 0", halted, instr);
    end
    fetch = 1'b1;
    tick();
    fetch = 1'b0;
    tick();
    tick();
    #2 rst_f = 1'b0;
    #1;
    checks++;
    if (im.im_req !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_now: req=%b busy=%b want 0 0", im.im_req, busy);
    end
    #1 rst_f = 1'b1;
    n0 = ir_count;
    im.im_rdy = 1'b1;
    im.im_data = 32'hF123_4567;
    tick();
    tick();
    im.im_rdy = 1'b0;
    checks++;
    if (instr !== 32'h0 || halted !== 1'b0 || ir_count !== n0) begin
      errors++;
      $display("FAIL late_rdy: instr=%h halted=%b pulses=%0d want 0 0 0",
               instr, halted, ir_count - n0);
    end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_branch();
    test_wrap();
    test_timeout();
    test_back_to_back_halt();
    test_reset_abort();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d expected IR loads never seen, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_W, 16, width of PC and instruction-memory address.
REQ-002 Parameter TIMEOUT, 16, maximum cycles spent waiting for IM_RDY before a fetch is abandoned.
REQ-003 CLK  input  1  single clock; all state changes on the rising edge.
REQ-004 RST_F  input  1  reset, asynchronous and active-low.
REQ-005 FETCH  input  1  one-cycle pulse from the control FSM requesting a fetch at the current PC.
REQ-006 PC_WRITE  input  1  PC update enable.
REQ-007 PC_SEL  input  1  0 = sequential PC, 1 = branch target.
REQ-008 BR_SEL  input  1  0 = relative branch, 1 = absolute branch; used only when PC_SEL=1.
REQ-009 PC_RST  input  1  synchronous PC clear.
REQ-010 IM_RDY  input  1  instruction memory data valid.
REQ-011 IM_DATA  input  32  instruction word from memory.
REQ-012 IM_REQ  output  1  instruction memory read request.
REQ-013 IM_ADDR  output  ADDR_W  read address, registered.
REQ-014 INSTR  output  32  instruction register (IR).
REQ-015 OPCODE  output  4  INSTR[31:28].
REQ-016 MM  output  4  INSTR[27:24].
REQ-017 PC  output  ADDR_W  program counter.
REQ-018 IR_VALID  output  1  one-cycle pulse after IR is loaded.
REQ-019 BUSY  output  1  high while a fetch is in progress.
REQ-020 FETCH_ERR  output  1  sticky timeout flag.
REQ-021 HALTED  output  1  set when a HLT opcode (15) is loaded into IR.

Function
REQ-022 The FSM SHALL have four states: IDLE, REQ, WAIT and HALT; BUSY is high in REQ and WAIT.
REQ-023 In IDLE, FETCH=1 SHALL latch IM_ADDR<=PC, move the FSM to REQ, and drive IM_REQ high from the next cycle.
REQ-024 In REQ, the FSM SHALL go to WAIT with IM_REQ and IM_ADDR held stable.
REQ-025 In WAIT, the first edge that samples IM_RDY=1 SHALL load INSTR<=IM_DATA, drop IM_REQ, pulse IR_VALID in the following cycle, and return the FSM to IDLE.
REQ-026 Fetch latency SHALL be 3 edges minimum: FETCH edge, REQ edge, then the capture edge.
REQ-027 A wait counter SHALL count cycles in WAIT; at TIMEOUT cycles without IM_RDY the block SHALL load INSTR<=0 (noop), set FETCH_ERR, pulse IR_VALID and return to IDLE.
REQ-028 FETCH_ERR SHALL clear on the next accepted FETCH.
REQ-029 FETCH asserted while BUSY=1 or in HALT SHALL be ignored.
REQ-030 PC update priority SHALL be: PC_RST (PC<=0), then PC_WRITE with PC_SEL=0 (PC<=PC+1), then PC_SEL=1 with BR_SEL=1 (PC<=INSTR[ADDR_W-1:0]), then PC_SEL=1 with BR_SEL=0 (PC<=PC+sign-extended INSTR[15:0]).
REQ-031 PC arithmetic SHALL wrap modulo 2^ADDR_W, with no overflow flag.
REQ-032 PC updates SHALL be permitted in any state; an in-flight IM_ADDR SHALL NOT change.
REQ-033 When IR is loaded with OPCODE=15, the FSM SHALL enter HALT, set HALTED and stay there until reset.
REQ-034 OPCODE and MM SHALL be combinational slices of INSTR.

Reset
REQ-035 RST_F low SHALL asynchronously force the FSM to IDLE and clear PC, IM_ADDR, INSTR, the wait counter, IM_REQ, IR_VALID, BUSY, FETCH_ERR and HALTED.
REQ-036 Reset mid-fetch SHALL abort the fetch; a late IM_RDY after release SHALL be ignored.

Structure
REQ-037 Opcode constants (NOOP=0, HLT=15), field positions and the FSM state encoding SHALL live in the shared CPU package.
REQ-038 Next-PC computation SHALL be a combinational sub-module named pc_next.

Verification
REQ-039 Reset, FETCH at PC=0, IM_RDY two cycles after IM_REQ with IM_DATA=0x81230004 -> IM_ADDR=0, INSTR=0x81230004, OPCODE=8, MM=1, one IR_VALID pulse.
REQ-040 PC=0x0010, PC_WRITE with PC_SEL=1, BR_SEL=0 and INSTR[15:0]=0xFFFC -> PC=0x000C; same with BR_SEL=1 and INSTR[15:0]=0x0040 -> PC=0x0040.
REQ-041 PC=0xFFFF, PC_WRITE with PC_SEL=0 -> PC=0x0000; PC_RST and PC_WRITE in the same cycle -> PC=0.
REQ-042 FETCH with IM_RDY held 0 -> after 16 cycles in WAIT, INSTR=0, FETCH_ERR=1, IM_REQ=0; next FETCH clears FETCH_ERR.
REQ-043 A second FETCH during WAIT -> ignored, IM_ADDR unchanged; IM_DATA=0xF0000000 -> HALTED=1, later FETCH ignored.
REQ-044 RST_F low while in WAIT -> IM_REQ=0 immediately; IM_RDY after release -> INSTR remains 0.
